pipe_ctrl: RTL and testbench

Pipeline sequencing and hazard controller for the RV32I 5-stage core. It sits beside the ID stage and consumes the decoder's register-usage outputs. It keeps its own in-flight destination scoreboard for EX/MEM/WB and drives stall, bubble, flush, PC-redirect and registered forwarding selects for every pipeline register. It also holds the core on illegal instructions until a trap handler acknowledges.

---
 rtl/pipe_ctrl_pkg.sv | 38 +++
 rtl/pipe_ctrl_if.sv | 58 +++++
 rtl/pipe_ctrl_hazard_scoreboard.sv | 77 +++++++
 rtl/pipe_ctrl.sv | 112 +++++++++++
 tb/tb_pipe_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared types and constants for the pipeline sequencing / hazard controller:
//   FSM state encoding, forwarding-select encoding, scoreboard entry layout and
//   the source-operand match helper used by the scoreboard.
package pipe_ctrl_pkg;

  localparam int XLEN  = 32;  // PC / redirect address width
  localparam int CNT_W = 32;  // stall performance counter width

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    PCTL_RUN      = 2'b00,
    PCTL_MEM_WAIT = 2'b01,
    PCTL_TRAP     = 2'b10
  } pctl_state_e;

  // EX operand source. "MEM" means the producer sits in EX now and will be
  // in MEM when the consumer reaches EX.
  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_REG = 2'b00;
  localparam fwd_sel_t FWD_MEM = 2'b01;
  localparam fwd_sel_t FWD_WB  = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  // A source operand depends on an in-flight entry when it is actually read,
  // is not x0, and names the entry's destination.
  function automatic logic src_hit(input logic en, input logic [4:0] rs,
                                   input sb_entry_t e);
    return en && (rs != ZERO_REG) && e.valid && (e.rd == rs);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if
//   Bundle between the core datapath and pipe_ctrl.
//   master : core side, drives ID decode info, EX jump, MEM busy, trap ack.
//   slave  : pipe_ctrl, drives stall/bubble/flush/redirect/forward/trap,
//            the stall counter, and debug visibility of FSM state and the
//            in-flight scoreboard ({EX, MEM, WB} in dbg_sb[2:0]).
//   There is no valid/ready handshake: id_valid_i simply qualifies the ID
//   fields in the cycle it is high, and every control output applies to the
//   same cycle (except fwd_*, which apply to the instruction now in EX).
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic             id_valid_i;
  logic             id_illegal_i;
  logic             id_rs1en_i;
  logic             id_rs2en_i;
  logic [4:0]       id_rs1_addr_i;
  logic [4:0]       id_rs2_addr_i;
  logic             id_rd_wen_i;
  logic [4:0]       id_rd_addr_i;
  logic             id_is_load_i;
  logic             ex_jump_i;
  logic [XLEN-1:0]  ex_jump_addr_i;
  logic             dmem_busy_i;
  logic             trap_ack_i;

  logic             stall_if_o;
  logic             stall_id_o;
  logic             freeze_o;
  logic             bubble_ex_o;
  logic             flush_id_o;
  logic             pc_redirect_o;
  logic [XLEN-1:0]  pc_redirect_addr_o;
  fwd_sel_t         fwd_rs1_o;
  fwd_sel_t         fwd_rs2_o;
  logic             trap_o;
  logic [CNT_W-1:0] stall_cnt_o;
  pctl_state_e      dbg_state;
  sb_entry_t [2:0]  dbg_sb;

  modport master (
    output id_valid_i, id_illegal_i, id_rs1en_i, id_rs2en_i, id_rs1_addr_i,
           id_rs2_addr_i, id_rd_wen_i, id_rd_addr_i, id_is_load_i, ex_jump_i,
           ex_jump_addr_i, dmem_busy_i, trap_ack_i,
    input  stall_if_o, stall_id_o, freeze_o, bubble_ex_o, flush_id_o,
           pc_redirect_o, pc_redirect_addr_o, fwd_rs1_o, fwd_rs2_o, trap_o,
           stall_cnt_o, dbg_state, dbg_sb
  );

  modport slave (
    input  id_valid_i, id_illegal_i, id_rs1en_i, id_rs2en_i, id_rs1_addr_i,
           id_rs2_addr_i, id_rd_wen_i, id_rd_addr_i, id_is_load_i, ex_jump_i,
           ex_jump_addr_i, dmem_busy_i, trap_ack_i,
    output stall_if_o, stall_id_o, freeze_o, bubble_ex_o, flush_id_o,
           pc_redirect_o, pc_redirect_addr_o, fwd_rs1_o, fwd_rs2_o, trap_o,
           stall_cnt_o, dbg_state, dbg_sb
  );
endinterface

// File: rtl/pipe_ctrl_hazard_scoreboard.sv
// hazard_scoreboard
//   Three-entry in-flight destination shift register (EX, MEM, WB) with
//   source-match, load-use detection and registered forwarding selects.
//   Ports: clk/rst_n; shift_en advances the pipeline (low = frozen);
//   bubble kills the ID instruction's insertion; id_* decode info;
//   load_use (comb), fwd_rs1/fwd_rs2 (registered), sb = {EX, MEM, WB}.
module hazard_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            shift_en,
  input  logic            bubble,
  input  logic            id_valid,
  input  logic            rs1en,
  input  logic [4:0]      rs1_addr,
  input  logic            rs2en,
  input  logic [4:0]      rs2_addr,
  input  logic            rd_wen,
  input  logic [4:0]      rd_addr,
  input  logic            is_load,
  output logic            load_use,
  output fwd_sel_t        fwd_rs1,
  output fwd_sel_t        fwd_rs2,
  output sb_entry_t [2:0] sb
);

  sb_entry_t ex_q, mem_q, wb_q;
  sb_entry_t ins;
  fwd_sel_t  fwd_rs1_nxt, fwd_rs2_nxt;

  // Youngest producer wins. WB needs no forwarding: the regfile is
  // write-first, so a WB-only match reads the register file directly.
  function automatic fwd_sel_t fwd_for(input logic en, input logic [4:0] rs,
                                       input sb_entry_t ex, input sb_entry_t mem);
    if (src_hit(en, rs, ex))       return FWD_MEM;
    else if (src_hit(en, rs, mem)) return FWD_WB;
    else                           return FWD_REG;
  endfunction

  assign load_use = id_valid && ex_q.is_load &&
                    (src_hit(rs1en, rs1_addr, ex_q) || src_hit(rs2en, rs2_addr, ex_q));

  assign fwd_rs1_nxt = fwd_for(rs1en, rs1_addr, ex_q, mem_q);
  assign fwd_rs2_nxt = fwd_for(rs2en, rs2_addr, ex_q, mem_q);

  always_comb begin
    ins         = '0;
    ins.valid   = id_valid && rd_wen && (rd_addr != ZERO_REG) && !bubble;
    ins.rd      = rd_addr;
    ins.is_load = is_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_rs1 <= FWD_REG;
      fwd_rs2 <= FWD_REG;
    end else if (shift_en) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ins;
      if (bubble || !id_valid) begin
        fwd_rs1 <= FWD_REG;
        fwd_rs2 <= FWD_REG;
      end else begin
        fwd_rs1 <= fwd_rs1_nxt;
        fwd_rs2 <= fwd_rs2_nxt;
      end
    end
  end

  assign sb = {ex_q, mem_q, wb_q};

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Pipeline sequencing and hazard controller for the 5-stage core.
//   Ports: clk, rst_n (async, active-low), bus (pipe_ctrl_if.slave) carrying
//   ID decode info, EX jump, MEM busy, trap ack in; stall/freeze/bubble/
//   flush/redirect, forwarding selects, trap, stall counter and debug out.
//   Priority: dmem_busy_i > ex_jump_i > illegal > load-use.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave bus
);

  pctl_state_e      state_q, state_nxt;
  logic             stall, freeze, bubble, flush, redirect, trap;
  logic             load_use;
  logic [CNT_W-1:0] cnt_q;

  hazard_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (!bus.freeze_o),
    .bubble   (bubble),
    .id_valid (bus.id_valid_i),
    .rs1en    (bus.id_rs1en_i),
    .rs1_addr (bus.id_rs1_addr_i),
    .rs2en    (bus.id_rs2en_i),
    .rs2_addr (bus.id_rs2_addr_i),
    .rd_wen   (bus.id_rd_wen_i),
    .rd_addr  (bus.id_rd_addr_i),
    .is_load  (bus.id_is_load_i),
    .load_use (load_use),
    .fwd_rs1  (bus.fwd_rs1_o),
    .fwd_rs2  (bus.fwd_rs2_o),
    .sb       (bus.dbg_sb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PCTL_RUN;
    else        state_q <= state_nxt;
  end

  // MEM_WAIT only records that the pipe is frozen; once busy drops the
  // controller behaves as RUN in that same cycle, so a pending load-use or
  // jump is handled without an extra dead cycle.
  always_comb begin
    state_nxt = state_q;
    stall     = 1'b0;
    freeze    = 1'b0;
    bubble    = 1'b0;
    flush     = 1'b0;
    redirect  = 1'b0;
    trap      = 1'b0;
    case (state_q)
      PCTL_RUN, PCTL_MEM_WAIT: begin
        if (bus.dmem_busy_i) begin
          stall     = 1'b1;
          freeze    = 1'b1;
          state_nxt = PCTL_MEM_WAIT;
        end else begin
          state_nxt = PCTL_RUN;
          if (bus.ex_jump_i) begin
            // Kills both IF-ID and the ID instruction; no trap, no stall.
            redirect = 1'b1;
            flush    = 1'b1;
            bubble   = 1'b1;
          end else if (bus.id_valid_i && bus.id_illegal_i) begin
            stall     = 1'b1;
            bubble    = 1'b1;
            state_nxt = PCTL_TRAP;
          end else if (load_use) begin
            stall  = 1'b1;
            bubble = 1'b1;
          end
        end
      end
      PCTL_TRAP: begin
        trap   = 1'b1;
        stall  = 1'b1;
        bubble = 1'b1;
        if (bus.dmem_busy_i) begin
          freeze = 1'b1;
        end else if (bus.trap_ack_i) begin
          flush     = 1'b1;
          state_nxt = PCTL_RUN;
        end
      end
      default: state_nxt = PCTL_RUN;
    endcase
  end

  // Combinational outputs are forced low while reset is asserted so the
  // core sees a quiet controller even with live inputs.
  assign bus.stall_if_o         = rst_n & stall;
  assign bus.stall_id_o         = rst_n & stall;
  assign bus.freeze_o           = rst_n & freeze;
  assign bus.bubble_ex_o        = rst_n & bubble;
  assign bus.flush_id_o         = rst_n & flush;
  assign bus.pc_redirect_o      = rst_n & redirect;
  assign bus.trap_o             = rst_n & trap;
  assign bus.pc_redirect_addr_o = bus.pc_redirect_o ? bus.ex_jump_addr_i : '0;
  assign bus.dbg_state          = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             cnt_q <= '0;
    else if (bus.stall_if_o && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
  end

  assign bus.stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
//   Directed self-checking bench for pipe_ctrl. Each cycle the expected
//   output vector {stall_if, stall_id, freeze, bubble_ex, flush_id,
//   pc_redirect, trap, fwd_rs1, fwd_rs2} is queued when inputs are driven
//   and popped/compared at the following falling edge.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  logic [10:0] exp_q[$];

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] ev(input bit si, input bit fz, input bit bx,
                                     input bit fl, input bit rd, input bit tr,
                                     input logic [1:0] f1, input logic [1:0] f2);
    return {si, si, fz, bx, fl, rd, tr, f1, f2};
  endfunction

  function automatic logic [10:0] outs();
    return {bus.stall_if_o, bus.stall_id_o, bus.freeze_o, bus.bubble_ex_o,
            bus.flush_id_o, bus.pc_redirect_o, bus.trap_o, bus.fwd_rs1_o, bus.fwd_rs2_o};
  endfunction

  // ---------------- drivers ----------------
  task automatic set_id(input bit v, input bit ill, input bit ld,
                        input int rd, input int rs1, input int rs2);
    bus.id_valid_i    = v;
    bus.id_illegal_i  = ill;
    bus.id_is_load_i  = ld;
    bus.id_rd_wen_i   = v & ~ill;
    bus.id_rd_addr_i  = 5'(rd);
    bus.id_rs1en_i    = v;
    bus.id_rs1_addr_i = 5'(rs1);
    bus.id_rs2en_i    = v;
    bus.id_rs2_addr_i = 5'(rs2);
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0);
    bus.ex_jump_i      = 1'b0;
    bus.ex_jump_addr_i = '0;
    bus.dmem_busy_i    = 1'b0;
    bus.trap_ack_i     = 1'b0;
  endtask

  // One pipeline cycle: queue expectation, compare at negedge, advance.
  task automatic step(input string tag, input logic [10:0] e);
    exp_q.push_back(e);
    @(negedge clk);
    check(tag, 32'(outs()), 32'(exp_q.pop_front()));
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    // Live inputs during reset must not leak to outputs.
    bus.ex_jump_i      = 1'b1;
    bus.ex_jump_addr_i = 32'hdead_beef;
    bus.dmem_busy_i    = 1'b1;
    set_id(1, 1, 0, 0, 0, 0);
    #12;
    check("rst_outs", 32'(outs()), 32'd0);
    check("rst_addr", bus.pc_redirect_addr_o, 32'd0);
    check("rst_cnt", bus.stall_cnt_o, 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(PCTL_RUN));
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    @(posedge clk);
    #1;

    // Load-use: lw x5 then add x6,x5,x1
    set_id(1, 0, 1, 5, 1, 0);  step("lu_lw",     ev(0,0,0,0,0,0,2'b00,2'b00));
    set_id(1, 0, 0, 6, 5, 1);  step("lu_stall",  ev(1,0,1,0,0,0,2'b00,2'b00));
    check("lu_cnt", bus.stall_cnt_o, 32'd1);
    step("lu_issue",  ev(0,0,0,0,0,0,2'b00,2'b00));
    idle();                    step("lu_fwd",    ev(0,0,0,0,0,0,2'b10,2'b00));

    // ALU forwarding: addi x5 ; add x6,x5,x5 ; addi x0 ; add x7,x0,x6
    set_id(1, 0, 0, 5, 1, 0);  step("alu_addi",  ev(0,0,0,0,0,0,2'b00,2'b00));
    set_id(1, 0, 0, 6, 5, 5);  step("alu_add",   ev(0,0,0,0,0,0,2'b00,2'b00));
    set_id(1, 0, 0, 0, 1, 0);  step("alu_fwd01", ev(0,0,0,0,0,0,2'b01,2'b01));
    set_id(1, 0, 0, 7, 0, 6);  step("alu_x0",    ev(0,0,0,0,0,0,2'b00,2'b00));
    idle();                    step("alu_fwd10", ev(0,0,0,0,0,0,2'b00,2'b10));

    // Jump with load-use in ID: jump wins, no stall
    set_id(1, 0, 1, 8, 1, 0);  step("jmp_lw",    ev(0,0,0,0,0,0,2'b00,2'b00));
    set_id(1, 0, 0, 9, 8, 0);
    bus.ex_jump_i = 1'b1;
    bus.ex_jump_addr_i = 32'h0000_0080;
    @(negedge clk);
    check("jmp_addr", bus.pc_redirect_addr_o, 32'h0000_0080);
    @(posedge clk);
    #1;
    // Replay the same inputs one cycle later: the load has moved to MEM,
    // so the pair is still a jump but no longer a load-use candidate.
    set_id(1, 0, 1, 8, 1, 0);
    step("jmp_redir", ev(0,0,1,1,1,0,2'b00,2'b00));
    idle();                    step("jmp_after", ev(0,0,0,0,0,0,2'b00,2'b00));
    check("jmp_cnt", bus.stall_cnt_o, 32'd1);

    // Illegal -> TRAP, ack on the fifth trap cycle
    set_id(1, 1, 0, 0, 0, 0);  step("ill_det",   ev(1,0,1,0,0,0,2'b00,2'b00));
    for (int i = 0; i < 4; i++) step("trap_hold", ev(1,0,1,0,0,1,2'b00,2'b00));
    bus.trap_ack_i = 1'b1;     step("trap_ack",  ev(1,0,1,1,0,1,2'b00,2'b00));
    idle();                    step("trap_exit", ev(0,0,0,0,0,0,2'b00,2'b00));
    check("trap_state", 32'(bus.dbg_state), 32'(PCTL_RUN));
    check("trap_cnt", bus.stall_cnt_o, 32'd7);

    // Illegal together with jump: no trap
    set_id(1, 1, 0, 0, 0, 0);
    bus.ex_jump_i = 1'b1;
    bus.ex_jump_addr_i = 32'h0000_0100;
    step("illj_jump", ev(0,0,1,1,1,0,2'b00,2'b00));
    idle();                    step("illj_none", ev(0,0,0,0,0,0,2'b00,2'b00));
    check("illj_cnt", bus.stall_cnt_o, 32'd7);

    // dmem_busy for 3 cycles over a load-use; fwd must hold through freeze
    set_id(1, 0, 0, 12, 1, 0); step("bz_addi",   ev(0,0,0,0,0,0,2'b00,2'b00));
    set_id(1, 0, 1, 10, 12, 0); step("bz_lw",    ev(0,0,0,0,0,0,2'b00,2'b00));
    set_id(1, 0, 0, 11, 10, 10);
    bus.dmem_busy_i = 1'b1;
    step("bz_frz1", ev(1,1,0,0,0,0,2'b01,2'b00));
    check("bz_state", 32'(bus.dbg_state), 32'(PCTL_MEM_WAIT));
    step("bz_frz2", ev(1,1,0,0,0,0,2'b01,2'b00));
    step("bz_frz3", ev(1,1,0,0,0,0,2'b01,2'b00));
    bus.dmem_busy_i = 1'b0;
    step("bz_lu",     ev(1,0,1,0,0,0,2'b01,2'b00));
    step("bz_issue",  ev(0,0,0,0,0,0,2'b00,2'b00));
    idle();                    step("bz_fwd",    ev(0,0,0,0,0,0,2'b10,2'b10));
    check("bz_cnt", bus.stall_cnt_o, 32'd11);

    // Reset in the middle of a trap
    set_id(1, 1, 0, 0, 0, 0);  step("rt_ill",    ev(1,0,1,0,0,0,2'b00,2'b00));
    step("rt_trap",   ev(1,0,1,0,0,1,2'b00,2'b00));
    bus.ex_jump_i = 1'b1;
    bus.ex_jump_addr_i = 32'h0000_0200;
    #2;
    rst_n = 1'b0;
    #1;
    check("rt_outs", 32'(outs()), 32'd0);
    check("rt_addr", bus.pc_redirect_addr_o, 32'd0);
    check("rt_cnt", bus.stall_cnt_o, 32'd0);
    check("rt_state", 32'(bus.dbg_state), 32'(PCTL_RUN));
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    @(posedge clk);
    #1;
    step("rt_after", ev(0,0,0,0,0,0,2'b00,2'b00));
    check("rt_state2", 32'(bus.dbg_state), 32'(PCTL_RUN));

    // ---------------- report ----------------
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
